enemy_wave_scheduler: RTL
=========================

ENEMY_WAVE_SCHEDULER -- requirements
Module: enemy_wave_scheduler

Interface
REQ-001 SPAWN_PERIOD, 50000000, clk cycles between spawn requests while running.
REQ-002 LEVEL_STEP, 8, kills per flying_rate increment.
REQ-003 START_LIVES, 3, lives loaded at game (re)start; range 1..3.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; starts or restarts a game.
REQ-007 pause  in  1  level; freezes motion and spawn timer while high.
REQ-008 hit  in  10  bullet collision per enemy slot.
REQ-009 touch_edge  in  10  per-slot "reached bottom edge" from the y counter bank.
REQ-010 at_top  in  10  per-slot "y coordinate equals 0".
REQ-011 c_en  out  10  per-slot enable to the y counter bank.
REQ-012 des  out  10  per-slot destroyed/clear request to the y counter bank.
REQ-013 move_en  out  1  enables the bank's move-rate counter.
REQ-014 flying_rate  out  2  speed select to the bank.
REQ-015 score  out  8  kills, saturating at 255.
REQ-016 lives  out  2  remaining lives.
REQ-017 game_over  out  1  high while in OVER.
REQ-018 spawn_pulse  out  1  one-cycle pulse when a slot is allocated.
REQ-019 spawn_idx  out  4  index 0..9 of the slot allocated; valid with spawn_pulse.

Function
REQ-020 Top FSM states SHALL be IDLE, CLEAR, RUN, OVER.
REQ-021 IDLE: start -> CLEAR; otherwise stay; move_en=0.
REQ-022 CLEAR: every non-FREE slot forced to RETIRING; move_en=1; when all slots FREE -> RUN, loading lives=START_LIVES, score=0, flying_rate=0, timer=SPAWN_PERIOD-1, pending=0, rr pointer=0.
REQ-023 RUN: move_en = ~pause; lives reaching 0 -> OVER on the next edge.
REQ-024 OVER: move_en=0, slot states frozen, game_over=1; start -> CLEAR.
REQ-025 Each slot SHALL be FREE (c_en=0, des=0), ACTIVE (c_en=1, des=0) or RETIRING (c_en=1, des=1).
REQ-026 RETIRING -> FREE on the first edge where at_top[i]=1 and des[i] has been high at least one full cycle.
REQ-027 ACTIVE slot with hit[i] -> RETIRING, score+1; hit/touch_edge on FREE or RETIRING slots ignored.
REQ-028 ACTIVE slot with touch_edge[i] and not hit[i] -> RETIRING, lives-1 saturating at 0.
REQ-029 Same-slot hit and touch_edge in one cycle: hit wins, no life lost.
REQ-030 Multiple slots in one cycle: score adds the popcount of qualifying hits; lives subtract the popcount of edge losses, floor 0.
REQ-031 Spawn timer: decrements in RUN while pause=0; at 0 sets pending=1 and reloads SPAWN_PERIOD-1; frozen otherwise.
REQ-032 Allocation: when pending=1, in RUN, pause=0, pick first FREE slot scanning from rr pointer with wrap 9->0; slot -> ACTIVE, spawn_pulse=1, spawn_idx=slot, rr=slot+1 mod 10, pending cleared; same-cycle registered outputs.
REQ-033 All slots busy: pending held, at most one outstanding; further timer expiries are dropped.
REQ-034 A slot freed and a new allocation SHALL NOT occur for the same slot in the same cycle (allocation sees prior-cycle state).
REQ-035 flying_rate = min(floor(score/LEVEL_STEP), 3), updated the cycle after score changes.
REQ-036 start in RUN SHALL be ignored.

Reset
REQ-037 reset=1 forces immediately: IDLE, all slots FREE, c_en=0, des=0, move_en=0, flying_rate=0, score=0, lives=0, game_over=0, spawn_pulse=0, spawn_idx=0, pending=0, rr=0, timer=SPAWN_PERIOD-1.
REQ-038 Reset asserted mid-game SHALL abandon all state; slots re-enter via CLEAR after the next start.

Verification (SPAWN_PERIOD=4, LEVEL_STEP=2)
REQ-039 reset, start, at_top=all 1 -> RUN within 2 cycles, lives=3; spawn_pulse every 4 cycles, spawn_idx 0,1,2...
REQ-040 Slot 0 ACTIVE, hit[0] and touch_edge[0] same cycle -> des[0]=1, score=1, lives=3; at_top[0]=1 next cycle -> c_en[0]=0.
REQ-041 Touch_edge on slots 1,2,3 simultaneously with lives=3 -> lives=0, next cycle game_over=1, move_en=0.
REQ-042 All 10 slots ACTIVE, two timer expiries -> no spawn_pulse; free slot 5 -> single spawn_pulse, spawn_idx=5.
REQ-043 Four hits -> flying_rate 0->1->2; eight hits saturate flying_rate at 3; pause=1 -> move_en=0 and timer frozen.
REQ-044 Reset asserted during RETIRING of slot 4 -> all outputs at reset values asynchronously, before next clk edge.

Source files
------------

// File: rtl/enemy_wave_scheduler.sv
// rtl/enemy_wave_scheduler.sv - enemy slot allocator, spawn timer, score/lives and game FSM
//
// Purpose: owns ten enemy slots (FREE / ACTIVE / RETIRING), issues periodic spawn
// requests into free slots round-robin, tracks kills (score), lives and speed level,
// and sequences the game through IDLE -> CLEAR -> RUN -> OVER.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   start, pause         game start/restart pulse; motion/spawn freeze level
//   hit, touch_edge      per-slot bullet collision and bottom-edge arrival
//   at_top               per-slot "y is back at 0" from the y counter bank
//   c_en, des            per-slot counter enable and destroy/clear request
//   move_en, flying_rate move-rate counter enable and speed select
//   score, lives         kill count (saturating) and remaining lives
//   game_over            high in OVER
//   spawn_pulse/idx      one-cycle allocation strobe and allocated slot index
module enemy_wave_scheduler #(
  parameter int SPAWN_PERIOD = 50000000,
  parameter int LEVEL_STEP   = 8,
  parameter int START_LIVES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] hit,
  input  logic [9:0] touch_edge,
  input  logic [9:0] at_top,
  output logic [9:0] c_en,
  output logic [9:0] des,
  output logic       move_en,
  output logic [1:0] flying_rate,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       spawn_pulse,
  output logic [3:0] spawn_idx
);

  localparam int TW = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(SPAWN_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_OVER} state_t;
  typedef enum logic [1:0] {S_FREE, S_ACTIVE, S_RETIRING} slot_t;

  state_t          state_q, state_d;
  slot_t           slot_q [10];
  slot_t           slot_d [10];
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic [1:0]      rate_q, rate_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pending_q, pending_d;
  logic [3:0]      rr_q, rr_d;
  logic            spawn_pulse_q, spawn_pulse_d;
  logic [3:0]      spawn_idx_q, spawn_idx_d;

  logic [3:0]      hits, losses;
  logic [8:0]      score_sum;
  logic [7:0]      level;
  logic            all_free, found;
  logic [4:0]      scan;
  logic [3:0]      alloc_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < 10; i++) slot_q[i] <= S_FREE;
      score_q       <= 8'd0;
      lives_q       <= 2'd0;
      rate_q        <= 2'd0;
      timer_q       <= TIMER_RELOAD;
      pending_q     <= 1'b0;
      rr_q          <= 4'd0;
      spawn_pulse_q <= 1'b0;
      spawn_idx_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      for (int i = 0; i < 10; i++) slot_q[i] <= slot_d[i];
      score_q       <= score_d;
      lives_q       <= lives_d;
      rate_q        <= rate_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      rr_q          <= rr_d;
      spawn_pulse_q <= spawn_pulse_d;
      spawn_idx_q   <= spawn_idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    for (int i = 0; i < 10; i++) slot_d[i] = slot_q[i];
    score_d       = score_q;
    lives_d       = lives_q;
    rate_d        = rate_q;
    timer_d       = timer_q;
    pending_d     = pending_q;
    rr_d          = rr_q;
    spawn_pulse_d = 1'b0;
    spawn_idx_d   = spawn_idx_q;
    hits          = 4'd0;
    losses        = 4'd0;
    score_sum     = 9'd0;
    level         = 8'd0;
    all_free      = 1'b1;
    found         = 1'b0;
    scan          = 5'd0;
    alloc_idx     = 4'd0;

    for (int i = 0; i < 10; i++) begin
      if (slot_q[i] != S_FREE) all_free = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end

      ST_CLEAR: begin
        // Drain the bank: everything retires and returns once its y is back at 0.
        for (int i = 0; i < 10; i++) begin
          if (slot_q[i] != S_FREE) begin
            if (slot_q[i] == S_RETIRING && at_top[i]) slot_d[i] = S_FREE;
            else                                      slot_d[i] = S_RETIRING;
          end
        end
        if (all_free) begin
          state_d   = ST_RUN;
          lives_d   = 2'(START_LIVES);
          score_d   = 8'd0;
          rate_d    = 2'd0;
          timer_d   = TIMER_RELOAD;
          pending_d = 1'b0;
          rr_d      = 4'd0;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < 10; i++) begin
          case (slot_q[i])
            S_ACTIVE: begin
              // A hit takes priority over the same slot reaching the edge.
              if (hit[i]) begin
                slot_d[i] = S_RETIRING;
                hits      = hits + 4'd1;
              end else if (touch_edge[i]) begin
                slot_d[i] = S_RETIRING;
                losses    = losses + 4'd1;
              end
            end
            // A slot in RETIRING at this edge has had des high for a full cycle.
            S_RETIRING: if (at_top[i]) slot_d[i] = S_FREE;
            default: ;
          endcase
        end

        score_sum = {1'b0, score_q} + {5'd0, hits};
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        lives_d   = (losses >= {2'd0, lives_q}) ? 2'd0 : lives_q - losses[1:0];

        // Level tracks the registered score, so it trails a score change by a cycle.
        level  = score_q / 8'(LEVEL_STEP);
        rate_d = (level > 8'd3) ? 2'd3 : level[1:0];

        if (!pause) begin
          // Allocation scans the prior-cycle slot states, so a slot freed on
          // this edge cannot be handed out on the same edge.
          if (pending_q) begin
            for (int k = 0; k < 10; k++) begin
              scan = {1'b0, rr_q} + 5'(k);
              if (scan >= 5'd10) scan = scan - 5'd10;
              if (!found && slot_q[scan[3:0]] == S_FREE) begin
                found     = 1'b1;
                alloc_idx = scan[3:0];
              end
            end
            if (found) begin
              slot_d[alloc_idx] = S_ACTIVE;
              spawn_pulse_d     = 1'b1;
              spawn_idx_d       = alloc_idx;
              rr_d              = (alloc_idx == 4'd9) ? 4'd0 : alloc_idx + 4'd1;
              pending_d         = 1'b0;
            end
          end
          // Only one request can be outstanding; an expiry while pending is dropped.
          if (timer_q == '0) begin
            pending_d = 1'b1;
            timer_d   = TIMER_RELOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end

        if (lives_q == 2'd0) state_d = ST_OVER;
      end

      ST_OVER: begin
        if (start) state_d = ST_CLEAR;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      c_en[i] = (slot_q[i] != S_FREE);
      des[i]  = (slot_q[i] == S_RETIRING);
    end
  end

  assign move_en     = (state_q == ST_CLEAR) || (state_q == ST_RUN && !pause);
  assign game_over   = (state_q == ST_OVER);
  assign flying_rate = rate_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign spawn_pulse = spawn_pulse_q;
  assign spawn_idx   = spawn_idx_q;

endmodule
